// File: rtl/mux_nx1_rr_pkg.sv
// Shared constants and helpers for the N-input round-robin/fixed multiplexer.
// Select width is derived here so the top and the arbiter always agree.
package mux_nx1_rr_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result    = result + 1;
            remaining = remaining >> 1;
        end
        return result;
    endfunction

    // A select port narrower than one bit is not expressible, so clamp to 1.
    function automatic int sel_width(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

endpackage

// File: rtl/mux_nx1_rr_arbiter.sv
// Combinational grant logic: either a fixed select or a rotating priority
// search that starts at ptr and wraps from N-1 back to 0.
module rr_arbiter_n
    import mux_nx1_rr_pkg::*;
#(
    parameter  int N  = 4,
    localparam int SW = sel_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [SW-1:0] ptr,
    input  logic          fixed_en,
    input  logic [SW-1:0] fixed_sel,
    output logic [N-1:0]  gnt_onehot,
    output logic [SW-1:0] gnt_id,
    output logic          gnt_any
);

    int start_idx;
    int scan_idx;

    // A select at or beyond N names no channel, so it simply yields no grant.
    always_comb begin
        gnt_onehot = '0;
        gnt_id     = '0;
        gnt_any    = 1'b0;
        start_idx  = (int'(ptr) < N) ? int'(ptr) : 0;
        scan_idx   = 0;
        if (fixed_en) begin
            for (int k = 0; k < N; k++) begin
                if ((int'(fixed_sel) == k) && req[k]) begin
                    gnt_onehot[k] = 1'b1;
                    gnt_id        = SW'(k);
                    gnt_any       = 1'b1;
                end
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                scan_idx = start_idx + i;
                if (scan_idx >= N) begin
                    scan_idx = scan_idx - N;
                end
                if (!gnt_any && req[scan_idx]) begin
                    gnt_onehot[scan_idx] = 1'b1;
                    gnt_id               = SW'(scan_idx);
                    gnt_any              = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/mux_nx1_rr.sv
// N-input, W-bit multiplexer with a registered, valid/ready output stage.
// Holds the round-robin pointer, the output register and the in_ready gating.
module mux_nx1_rr
    import mux_nx1_rr_pkg::*;
#(
    parameter  int N  = 4,
    parameter  int W  = 1,
    localparam int SW = sel_width(N)
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            mode,
    input  logic [SW-1:0]   s,
    input  logic [N*W-1:0]  in_data,
    input  logic [N-1:0]    in_valid,
    output logic [N-1:0]    in_ready,
    output logic [W-1:0]    out_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [SW-1:0]   grant_id
);

    logic [SW-1:0] rr_ptr;
    logic [SW-1:0] next_ptr;
    logic [N-1:0]  gnt_onehot;
    logic [SW-1:0] gnt_id;
    logic          gnt_any;
    logic          load_ok;
    logic          do_load;
    logic [W-1:0]  sel_data;

    rr_arbiter_n #(
        .N (N)
    ) u_arbiter (
        .req        (in_valid),
        .ptr        (rr_ptr),
        .fixed_en   (mode == MODE_FIXED),
        .fixed_sel  (s),
        .gnt_onehot (gnt_onehot),
        .gnt_id     (gnt_id),
        .gnt_any    (gnt_any)
    );

    // The register can accept a word when empty or when it drains this edge.
    assign load_ok  = !out_valid || out_ready;
    assign do_load  = load_ok && gnt_any;
    assign in_ready = (load_ok && !reset) ? (gnt_onehot & in_valid) : '0;
    assign next_ptr = (gnt_id == SW'(N - 1)) ? '0 : gnt_id + 1'b1;

    always_comb begin
        sel_data = '0;
        for (int k = 0; k < N; k++) begin
            if (gnt_onehot[k]) begin
                sel_data = in_data[k*W +: W];
            end
        end
    end

    // Pointer only advances on round-robin transfers so fixed mode leaves it untouched.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            grant_id  <= '0;
            rr_ptr    <= '0;
        end else if (do_load) begin
            out_valid <= 1'b1;
            out_data  <= sel_data;
            grant_id  <= gnt_id;
            if (mode == MODE_RR) begin
                rr_ptr <= next_ptr;
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    a_ready_onehot: assert property (@(posedge clock) disable iff (reset)
        $onehot0(in_ready));

    a_grant_legal: assert property (@(posedge clock) disable iff (reset)
        out_valid |-> (int'(grant_id) < N));

    a_ptr_legal: assert property (@(posedge clock) disable iff (reset)
        int'(rr_ptr) < N);

    a_hold_stable: assert property (@(posedge clock) disable iff (reset)
        (out_valid && !out_ready) |=> ($stable(out_data) && $stable(grant_id) && out_valid));

endmodule

// File: tb/tb_mux_nx1_rr.sv
// Bench for mux_nx1_rr: directed scenarios plus random traffic on an N=4 and
// an N=3 instance, both checked against a queue-free behavioural model.
module tb_mux_nx1_rr;

    logic        clock;
    logic        reset;

    logic        mode4;
    logic [1:0]  s4;
    logic [31:0] in_data4;
    logic [3:0]  in_valid4;
    logic [3:0]  in_ready4;
    logic [7:0]  out_data4;
    logic        out_valid4;
    logic        out_ready4;
    logic [1:0]  grant_id4;

    logic        mode3;
    logic [1:0]  s3;
    logic [23:0] in_data3;
    logic [2:0]  in_valid3;
    logic [2:0]  in_ready3;
    logic [7:0]  out_data3;
    logic        out_valid3;
    logic        out_ready3;
    logic [1:0]  grant_id3;

    int total;
    int bad;

    int         m_ptr[2];
    bit         m_ov[2];
    logic [7:0] m_od[2];
    int         m_gid[2];

    mux_nx1_rr #(.N(4), .W(8)) dut4 (
        .clock     (clock),
        .reset     (reset),
        .mode      (mode4),
        .s         (s4),
        .in_data   (in_data4),
        .in_valid  (in_valid4),
        .in_ready  (in_ready4),
        .out_data  (out_data4),
        .out_valid (out_valid4),
        .out_ready (out_ready4),
        .grant_id  (grant_id4)
    );

    mux_nx1_rr #(.N(3), .W(8)) dut3 (
        .clock     (clock),
        .reset     (reset),
        .mode      (mode3),
        .s         (s3),
        .in_data   (in_data3),
        .in_valid  (in_valid3),
        .in_ready  (in_ready3),
        .out_data  (out_data3),
        .out_valid (out_valid3),
        .out_ready (out_ready3),
        .grant_id  (grant_id3)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Returns the channel that wins under the stated rules, or -1 for no grant.
    function automatic int model_grant(input int inst, input int n, input bit md, input int sel, input logic [3:0] v);
        if (!md) begin
            if (sel < n) begin
                if (v[sel]) return sel;
            end
            return -1;
        end
        for (int i = 0; i < n; i++) begin
            int c;
            c = (m_ptr[inst] + i) % n;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_ptr[i] = 0;
            m_ov[i]  = 1'b0;
            m_od[i]  = 8'h00;
            m_gid[i] = 0;
        end
    endtask

    // Applies a reset mid-cycle and checks that everything clears without a clock edge.
    task automatic reset_all();
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check_output("rst_ov4", 32'(out_valid4), 32'd0);
        check_output("rst_od4", 32'(out_data4), 32'd0);
        check_output("rst_gid4", 32'(grant_id4), 32'd0);
        check_output("rst_rdy4", 32'(in_ready4), 32'd0);
        check_output("rst_ov3", 32'(out_valid3), 32'd0);
        check_output("rst_rdy3", 32'(in_ready3), 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    // One clock: check combinational ready, take the edge, then check the outputs.
    task automatic apply_stimulus();
        int         g4;
        int         g3;
        bit         lo4;
        bit         lo3;
        logic [7:0] d4;
        logic [7:0] d3;
        bit         md4;
        bit         md3;
        bit         or4;
        bit         or3;
        #1;
        md4 = mode4;
        md3 = mode3;
        or4 = out_ready4;
        or3 = out_ready3;
        g4  = model_grant(0, 4, md4, int'(s4), in_valid4);
        g3  = model_grant(1, 3, md3, int'(s3), {1'b0, in_valid3});
        lo4 = !m_ov[0] || or4;
        lo3 = !m_ov[1] || or3;
        d4  = (g4 >= 0) ? in_data4[g4*8 +: 8] : 8'h00;
        d3  = (g3 >= 0) ? in_data3[g3*8 +: 8] : 8'h00;
        check_output("rdy4", 32'(in_ready4), (lo4 && g4 >= 0) ? (32'd1 << g4) : 32'd0);
        check_output("rdy3", 32'(in_ready3), (lo3 && g3 >= 0) ? (32'd1 << g3) : 32'd0);
        @(posedge clock);
        if (lo4 && g4 >= 0) begin
            m_ov[0]  = 1'b1;
            m_od[0]  = d4;
            m_gid[0] = g4;
            if (md4) m_ptr[0] = (g4 + 1) % 4;
        end else if (or4) begin
            m_ov[0] = 1'b0;
        end
        if (lo3 && g3 >= 0) begin
            m_ov[1]  = 1'b1;
            m_od[1]  = d3;
            m_gid[1] = g3;
            if (md3) m_ptr[1] = (g3 + 1) % 3;
        end else if (or3) begin
            m_ov[1] = 1'b0;
        end
        #1;
        check_output("ov4", 32'(out_valid4), 32'(m_ov[0]));
        check_output("od4", 32'(out_data4), 32'(m_od[0]));
        check_output("gid4", 32'(grant_id4), 32'(m_gid[0]));
        check_output("ov3", 32'(out_valid3), 32'(m_ov[1]));
        check_output("od3", 32'(out_data3), 32'(m_od[1]));
        check_output("gid3", 32'(grant_id3), 32'(m_gid[1]));
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        reset      = 1'b1;
        mode4      = 1'b0;
        s4         = 2'd0;
        in_data4   = '0;
        in_valid4  = '0;
        out_ready4 = 1'b0;
        mode3      = 1'b0;
        s3         = 2'd0;
        in_data3   = '0;
        in_valid3  = '0;
        out_ready3 = 1'b0;
        model_reset();
        #12;
        check_output("init_ov4", 32'(out_valid4), 32'd0);
        check_output("init_od4", 32'(out_data4), 32'd0);
        check_output("init_gid4", 32'(grant_id4), 32'd0);
        check_output("init_rdy4", 32'(in_ready4), 32'd0);
        check_output("init_ov3", 32'(out_valid3), 32'd0);
        reset = 1'b0;

        // Fixed select of channel 2.
        mode4      = 1'b0;
        s4         = 2'd2;
        in_valid4  = 4'b0100;
        in_data4   = 32'h00A5_0000;
        out_ready4 = 1'b1;
        apply_stimulus();
        check_output("t1_ov", 32'(out_valid4), 32'd1);
        check_output("t1_od", 32'(out_data4), 32'hA5);
        check_output("t1_gid", 32'(grant_id4), 32'd2);
        in_valid4 = 4'b0000;
        apply_stimulus();

        // Full-rate round robin with every channel requesting.
        reset_all();
        mode4     = 1'b1;
        in_valid4 = 4'b1111;
        in_data4  = 32'h4433_2211;
        for (int i = 0; i < 8; i++) begin
            apply_stimulus();
            check_output("t2_gid", 32'(grant_id4), 32'(i % 4));
            check_output("t2_ov", 32'(out_valid4), 32'd1);
        end

        // Back-pressure holds the word and blocks every input.
        reset_all();
        out_ready4 = 1'b0;
        apply_stimulus();
        for (int i = 0; i < 3; i++) begin
            apply_stimulus();
            check_output("t3_rdy", 32'(in_ready4), 32'd0);
            check_output("t3_gid", 32'(grant_id4), 32'd0);
            check_output("t3_od", 32'(out_data4), 32'h11);
        end
        out_ready4 = 1'b1;
        apply_stimulus();
        check_output("t3_next", 32'(grant_id4), 32'd1);

        // Three channels: wrap from 2 to 0, then an out-of-range fixed select.
        reset_all();
        in_valid4  = 4'b0000;
        mode3      = 1'b1;
        in_valid3  = 3'b111;
        in_data3   = 24'h33_2211;
        out_ready3 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            apply_stimulus();
            check_output("t4_gid", 32'(grant_id3), 32'(i % 3));
        end
        mode3 = 1'b0;
        s3    = 2'd3;
        #1;
        check_output("t4_rdy", 32'(in_ready3), 32'd0);
        apply_stimulus();
        check_output("t4_noload", 32'(out_valid3), 32'd0);
        in_valid3 = 3'b000;

        // Asynchronous reset while a word is held.
        mode4      = 1'b1;
        in_valid4  = 4'b1111;
        out_ready4 = 1'b0;
        apply_stimulus();
        check_output("t5_held", 32'(out_valid4), 32'd1);
        reset_all();
        out_ready4 = 1'b1;
        apply_stimulus();
        check_output("t5_first", 32'(grant_id4), 32'd0);

        // Sparse requests: channel 3, then channel 1 found by wrap-around.
        reset_all();
        in_valid4 = 4'b1000;
        apply_stimulus();
        check_output("t6_g3", 32'(grant_id4), 32'd3);
        in_valid4 = 4'b0010;
        apply_stimulus();
        check_output("t6_g1", 32'(grant_id4), 32'd1);

        // Random traffic on both instances.
        for (int i = 0; i < 400; i++) begin
            mode4      = 1'($urandom_range(0, 1));
            s4         = 2'($urandom_range(0, 3));
            in_valid4  = 4'($urandom);
            in_data4   = $urandom;
            out_ready4 = ($urandom_range(0, 3) != 0);
            mode3      = 1'($urandom_range(0, 1));
            s3         = 2'($urandom_range(0, 3));
            in_valid3  = 3'($urandom);
            in_data3   = 24'($urandom);
            out_ready3 = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 99) == 0) begin
                reset_all();
            end
            apply_stimulus();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
